// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with thresholds, occupancy count, sticky errors and optional FWFT read.
// Latency: write visible in count/flags after 1 edge; standard read data 1 edge after accept, FWFT shows head at once.
// Backpressure: writes while full and reads while empty are dropped (not queued) and latch overflow/underflow.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   datain, we        write data and write request
//   re                read request (FWFT: pop the word currently on dataout)
//   dataout, valid    read data and its qualifier
//   empty, full       count == 0 / count == DEPTH
//   almost_empty/full count <= AE_LEVEL / count >= AF_LEVEL
//   count             occupancy 0..DEPTH
//   overflow          sticky, write attempted while full
//   underflow         sticky, read attempted while empty
module fifo_sync_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter bit FWFT     = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           datain,
  input  logic                       we,
  input  logic                       re,
  output logic [WIDTH-1:0]           dataout,
  output logic                       valid,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_empty,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             wr_acc;
  logic             rd_acc;

  // Flags decode the count register only, so they never see we/re combinationally.
  assign empty        = (cnt == '0);
  assign full         = (cnt == CW'(DEPTH));
  assign almost_empty = (cnt <= CW'(AE_LEVEL));
  assign almost_full  = (cnt >= CW'(AF_LEVEL));
  assign count        = cnt;

  // A full FIFO refuses a write even when a read frees a slot in the same cycle;
  // likewise an empty FIFO refuses a read even when a write arrives alongside it.
  assign wr_acc = we && !full;
  assign rd_acc = re && !empty;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (!reset && wr_acc) begin
      mem[wr_ptr] <= datain;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (we && full)  overflow  <= 1'b1;
      if (re && empty) underflow <= 1'b1;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      // Head of queue is shown straight from memory; the pointer and count are
      // both registered, so the next word appears the cycle after a pop.
      // When empty the bus is driven to zero rather than stale storage.
      assign dataout = empty ? '0 : mem[rd_ptr];
      assign valid   = !empty;
    end else begin : g_std
      logic [WIDTH-1:0] dout_q;
      logic             valid_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          dout_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= rd_acc;
          if (rd_acc) dout_q <= mem[rd_ptr];
        end
      end

      assign dataout = dout_q;
      assign valid   = valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_sync_param.sv
module tb_fifo_sync_param;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int CW = 5;
  localparam int NV = 35;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [W-1:0]  datain, datain_f;
  logic          we, re, we_f, re_f;

  logic [W-1:0]  dataout, dataout_f;
  logic          valid, empty, full, almost_empty, almost_full, overflow, underflow;
  logic          valid_f, empty_f, full_f, almost_empty_f, almost_full_f, overflow_f, underflow_f;
  logic [CW-1:0] count, count_f;

  fifo_sync_param #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1'b0)) dut (
    .clk(clk), .reset(reset), .datain(datain), .we(we), .re(re),
    .dataout(dataout), .valid(valid), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  fifo_sync_param #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1'b1)) dut_f (
    .clk(clk), .reset(reset), .datain(datain_f), .we(we_f), .re(re_f),
    .dataout(dataout_f), .valid(valid_f), .empty(empty_f), .full(full_f),
    .almost_empty(almost_empty_f), .almost_full(almost_full_f), .count(count_f),
    .overflow(overflow_f), .underflow(underflow_f)
  );

  typedef struct {
    logic          we;
    logic          re;
    logic [W-1:0]  din;
    logic [CW-1:0] cnt;
    logic          vld;
    logic          chk_dout;
    logic [W-1:0]  dout;
    logic          full;
    logic          empty;
    logic          af;
    logic          ae;
    logic          ovf;
    logic          unf;
  } vec_t;

  vec_t vecs [NV];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic r, input logic [W-1:0] d);
    @(negedge clk);
    we = w; re = r; datain = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_std(input int idx);
    chk("rst_count", idx, count, 0);
    chk("rst_empty", idx, empty, 1);
    chk("rst_ae", idx, almost_empty, 1);
    chk("rst_full", idx, full, 0);
    chk("rst_af", idx, almost_full, 0);
    chk("rst_valid", idx, valid, 0);
    chk("rst_dout", idx, dataout, 0);
    chk("rst_ovf", idx, overflow, 0);
    chk("rst_unf", idx, underflow, 0);
  endtask

  // Expected status for a given occupancy with AF_LEVEL=14, AE_LEVEL=2.
  function automatic vec_t mk(input logic w, input logic r, input logic [W-1:0] d, input int c,
                              input logic v, input logic cd, input logic [W-1:0] dq,
                              input logic ov, input logic un);
    vec_t t;
    t.we = w; t.re = r; t.din = d; t.cnt = CW'(c); t.vld = v; t.chk_dout = cd; t.dout = dq;
    t.full = (c == 16); t.empty = (c == 0); t.af = (c >= 14); t.ae = (c <= 2);
    t.ovf = ov; t.unf = un;
    return t;
  endfunction

  initial begin
    int k;
    int rd_exp;
    reset = 1'b1; we = 0; re = 0; datain = '0; we_f = 0; re_f = 0; datain_f = '0;

    // Fill 0x01..0x10, one overflow attempt, drain 16, one underflow attempt, one idle.
    k = 0;
    for (int i = 0; i < 16; i++) begin vecs[k] = mk(1, 0, W'(i + 1), i + 1, 0, 0, 0, 0, 0); k++; end
    vecs[k] = mk(1, 0, 8'hAA, 16, 0, 0, 0, 1, 0); k++;
    for (int i = 0; i < 16; i++) begin vecs[k] = mk(0, 1, 8'h00, 15 - i, 1, 1, W'(i + 1), 1, 0); k++; end
    vecs[k] = mk(0, 1, 8'h00, 0, 0, 1, 8'h10, 1, 1); k++;
    vecs[k] = mk(0, 0, 8'h00, 0, 0, 1, 8'h10, 1, 1); k++;

    // Reset state for both modes
    step(); step();
    chk_reset_std(0);
    chk("rst_f_count", 0, count_f, 0);
    chk("rst_f_valid", 0, valid_f, 0);
    chk("rst_f_dout", 0, dataout_f, 0);
    chk("rst_f_empty", 0, empty_f, 1);
    @(negedge clk); reset = 1'b0;

    // FWFT: first word falls through with no read request
    @(negedge clk); we_f = 1; datain_f = 8'h5C;
    step();
    chk("fwft_first_dout", 0, dataout_f, 8'h5C);
    chk("fwft_first_valid", 0, valid_f, 1);
    chk("fwft_first_count", 0, count_f, 1);
    @(negedge clk); datain_f = 8'h33;
    step();
    chk("fwft_head_hold", 0, dataout_f, 8'h5C);
    chk("fwft_count2", 0, count_f, 2);
    @(negedge clk); we_f = 0; re_f = 1;
    step();
    chk("fwft_pop_dout", 0, dataout_f, 8'h33);
    chk("fwft_pop_valid", 0, valid_f, 1);
    chk("fwft_pop_count", 0, count_f, 1);
    step();
    chk("fwft_last_valid", 0, valid_f, 0);
    chk("fwft_last_empty", 0, empty_f, 1);
    chk("fwft_last_unf", 0, underflow_f, 0);
    step();
    chk("fwft_unf", 0, underflow_f, 1);
    chk("fwft_unf_count", 0, count_f, 0);
    @(negedge clk); re_f = 0;

    // Table-driven fill / overflow / drain / underflow on the standard-mode FIFO
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].we, vecs[i].re, vecs[i].din);
      step();
      chk("count", i, count, vecs[i].cnt);
      chk("valid", i, valid, vecs[i].vld);
      if (vecs[i].chk_dout) chk("dataout", i, dataout, vecs[i].dout);
      chk("full", i, full, vecs[i].full);
      chk("empty", i, empty, vecs[i].empty);
      chk("almost_full", i, almost_full, vecs[i].af);
      chk("almost_empty", i, almost_empty, vecs[i].ae);
      chk("overflow", i, overflow, vecs[i].ovf);
      chk("underflow", i, underflow, vecs[i].unf);
    end

    // Move pointers to wr=14, rd=6 with count=8, then 40 cycles of simultaneous write+read
    for (int i = 0; i < 14; i++) begin drive(1, 0, W'(i)); step(); end
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 8'h00); step();
      chk("pre_wrap_dout", i, dataout, i);
    end
    chk("pre_wrap_count", 0, count, 8);
    rd_exp = 6;
    for (int j = 0; j < 40; j++) begin
      drive(1, 1, W'(14 + j)); step();
      chk("wrap_count", j, count, 8);
      chk("wrap_valid", j, valid, 1);
      chk("wrap_dout", j, dataout, rd_exp);
      rd_exp++;
    end

    // Build count=9 with overflow set, then reset mid-operation with we held high
    for (int i = 0; i < 8; i++) begin drive(1, 0, W'(54 + i)); step(); end
    chk("refill_full", 0, full, 1);
    drive(1, 0, 8'hAA); step();
    chk("ovf2_count", 0, count, 16);
    for (int i = 0; i < 7; i++) begin
      drive(0, 1, 8'h00); step();
      chk("pre_rst_dout", i, dataout, rd_exp);
      rd_exp++;
    end
    chk("pre_rst_count", 0, count, 9);
    chk("sticky_ovf", 0, overflow, 1);
    chk("sticky_unf", 0, underflow, 1);

    @(negedge clk); reset = 1'b1; we = 1; re = 0; datain = 8'h77;
    step();
    chk_reset_std(1);
    @(negedge clk); reset = 1'b0; we = 0; re = 1;
    step();
    chk("post_rst_unf", 0, underflow, 1);
    chk("post_rst_valid", 0, valid, 0);
    chk("post_rst_count", 0, count, 0);
    chk("post_rst_dout", 0, dataout, 0);
    chk("post_rst_ovf", 0, overflow, 0);
    @(negedge clk); re = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
